// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory responder.
//   - MMIO page base and register offsets
//   - STATUS register bit positions
//   - is_mmio(): page decode helper
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_GPIO   = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;

  localparam int ST_CNT_LSB = 0;
  localparam int ST_CNT_MSB = 4;
  localparam int ST_EMPTY   = 8;
  localparam int ST_FULL    = 9;
  localparam int ST_OVF     = 16;

  // The whole top 256-byte page is I/O; everything else is RAM.
  function automatic logic is_mmio(input logic [31:0] a);
    return a[31:8] == MMIO_BASE[31:8];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
//   clk, rst_n     : clock, async active-low reset
//   push, w_data   : write request and data (accepted when not full, or when
//                    a pop happens in the same cycle)
//   pop            : read request (ignored when empty)
//   r_data         : head entry, forced to 0 while empty
//   full, empty    : occupancy flags
//   count          : number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         w_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         r_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Gating with empty keeps the head at 0 after reset without clearing storage.
  assign r_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: storage arrays are deliberately left out of reset; only the pointers
  // define what is valid, and an unreset array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= w_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the core's data port.
//   clk, rst          : clock, async active-low reset
//   we, oe            : write / read strobes
//   addr, w_data      : byte address and write data
//   r_data            : read data, one cycle after oe, held while oe is low
//   tx_valid, tx_data : transmit FIFO head (valid/ready byte stream)
//   tx_ready          : sink accepts the head byte
//   gpio              : general-purpose register contents
// Address map: page 0xFFFFFF00 holds CYCLE/GPIO/TXDATA/STATUS, every other
// address hits a 2^RAM_AW-word RAM that aliases across the space.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        oe,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] gpio
);

  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  logic              sel_mmio;
  logic [7:0]        off;
  logic [RAM_AW-1:0] word_idx;

  assign sel_mmio = is_mmio(addr);
  assign off      = addr[7:0];
  assign word_idx = addr[RAM_AW+1:2];

  // ---------------- RAM (synchronous read, read-before-write) -------------
  logic [31:0] ram [2**RAM_AW];
  logic [31:0] ram_q;

  always_ff @(posedge clk) begin
    if (we && !sel_mmio) ram[word_idx] <= w_data;
    if (oe && !sel_mmio) ram_q <= ram[word_idx];
  end

  // ---------------- Transmit FIFO -----------------------------------------
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;

  assign fifo_push = we && sel_mmio && (off == OFF_TXDATA);
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push   (fifo_push),
    .w_data (w_data[7:0]),
    .pop    (fifo_pop),
    .r_data (tx_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // ---------------- MMIO registers ----------------------------------------
  logic [31:0] cycle_cnt;
  logic        overflow;
  logic [31:0] status;
  logic [31:0] mmio_rd;
  logic [31:0] mmio_q;
  logic        rd_from_ram;

  always_comb begin
    status                        = '0;
    status[ST_CNT_MSB:ST_CNT_LSB] = 5'(fifo_count);
    status[ST_EMPTY]              = fifo_empty;
    status[ST_FULL]               = fifo_full;
    status[ST_OVF]                = overflow;
  end

  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational; an unassigned path would infer a latch.
  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_CYCLE:  mmio_rd = cycle_cnt;
      OFF_GPIO:   mmio_rd = gpio;
      OFF_STATUS: mmio_rd = status;
      default:    mmio_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      gpio        <= '0;
      overflow    <= 1'b0;
      mmio_q      <= '0;
      rd_from_ram <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (we && sel_mmio && (off == OFF_GPIO)) gpio <= w_data;
      if (we && sel_mmio && (off == OFF_STATUS) && w_data[ST_OVF]) overflow <= 1'b0;
      // A dropped push in the same cycle as a clear leaves overflow set.
      if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (oe) begin
        rd_from_ram <= !sel_mmio;
        if (sel_mmio) mmio_q <= mmio_rd;
      end
    end
  end

  // Both sources are registered and only reload on oe, so the mux output
  // holds its value while oe is low.
  assign r_data = rd_from_ram ? ram_q : mmio_q;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  localparam int RAM_AW = 10;
  localparam int DEPTH  = 8;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF00;
  localparam logic [31:0] A_GPIO   = 32'hFFFF_FF04;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_FF08;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF0C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, oe = 1'b0, tx_ready = 1'b0;
  logic [31:0] addr = '0, w_data = '0;
  logic [31:0] r_data, gpio;
  logic        tx_valid;
  logic [7:0]  tx_data;

  dmem_resp #(.RAM_AW(RAM_AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .oe       (oe),
    .addr     (addr),
    .w_data   (w_data),
    .r_data   (r_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .gpio     (gpio)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- Behavioural model -------------------------------------
  logic [31:0] m_ram [int unsigned];
  logic [7:0]  m_q [$];
  logic [31:0] m_gpio = '0, m_cycle = '0, m_r = '0;
  bit          m_r_known = 1'b1;
  bit          m_ovf = 1'b0;
  int          preload_seq = 0, seen_seq = 0;
  logic [31:0] preload_val = '0;

  task automatic model_step();
    int          cnt  = m_q.size();
    bit          pop  = (cnt > 0) && tx_ready;
    bit          mm   = (addr[31:8] == 24'hFFFFFF);
    int unsigned k    = (addr >> 2) & ((1 << RAM_AW) - 1);
    bit          push = 1'b0;
    logic [31:0] st   = 32'(cnt);
    if (cnt == 0)     st[8]  = 1'b1;
    if (cnt == DEPTH) st[9]  = 1'b1;
    if (m_ovf)        st[16] = 1'b1;
    if (oe) begin
      if (mm) begin
        m_r_known = 1'b1;
        case (addr[7:0])
          8'h00:   m_r = m_cycle;
          8'h04:   m_r = m_gpio;
          8'h0C:   m_r = st;
          default: m_r = '0;
        endcase
      end else if (m_ram.exists(k)) begin
        m_r = m_ram[k];
        m_r_known = 1'b1;
      end else begin
        m_r_known = 1'b0;
      end
    end
    if (we) begin
      if (mm) begin
        case (addr[7:0])
          8'h04: m_gpio = w_data;
          8'h08: push = 1'b1;
          8'h0C: if (w_data[16]) m_ovf = 1'b0;
          default: ;
        endcase
      end else begin
        m_ram[k] = w_data;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (cnt < DEPTH || pop) m_q.push_back(w_data[7:0]);
      else m_ovf = 1'b1;
    end
    m_cycle = m_cycle + 32'd1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_gpio = '0; m_cycle = '0; m_ovf = 1'b0; m_r = '0; m_r_known = 1'b1;
      m_q.delete();
    end else begin
      if (preload_seq != seen_seq) begin
        m_cycle  = preload_val;
        seen_seq = preload_seq;
      end
      model_step();
    end
  end

  // Continuous compare, away from the active edge.
  always @(negedge clk) begin
    if (m_r_known) check("r_data", r_data, m_r);
    check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    check("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    check("gpio", gpio, m_gpio);
  end

  // ---------------- Stimulus ----------------------------------------------
  task automatic cyc(input logic w, input logic o, input logic [31:0] a,
                     input logic [31:0] d, input logic rdy);
    we = w; oe = o; addr = a; w_data = d; tx_ready = rdy;
    @(posedge clk); #1;
  endtask

  logic [7:0] got [$];
  logic [7:0] offs [5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Counter: reading at the 10th edge out of reset returns 9.
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, A_CYCLE, 0, 0);
    check("cycle_edge10", r_data, 32'd9);

    // Counter wrap via preload.
    preload_val = 32'hFFFF_FFFE;
    preload_seq++;
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1 release dut.cycle_cnt;
    cyc(0, 1, A_CYCLE, 0, 0);
    check("cycle_pre", r_data, 32'hFFFF_FFFE);
    cyc(0, 1, A_CYCLE, 0, 0);
    check("cycle_max", r_data, 32'hFFFF_FFFF);
    cyc(0, 1, A_CYCLE, 0, 0);
    check("cycle_wrap", r_data, 32'h0);

    // RAM write/read and alias.
    cyc(1, 0, 32'h40, 32'hDEAD_BEEF, 0);
    cyc(0, 1, 32'h40, 0, 0);
    check("ram_rd", r_data, 32'hDEAD_BEEF);
    cyc(0, 1, 32'h40 + (4 << RAM_AW), 0, 0);
    check("ram_alias", r_data, 32'hDEAD_BEEF);
    cyc(0, 0, 32'h40, 0, 0);
    check("ram_hold", r_data, 32'hDEAD_BEEF);

    // Read-before-write.
    cyc(1, 0, 32'h80, 32'h1111_1111, 0);
    cyc(1, 1, 32'h80, 32'h2222_2222, 0);
    check("rbw_old", r_data, 32'h1111_1111);
    cyc(0, 1, 32'h80, 0, 0);
    check("rbw_new", r_data, 32'h2222_2222);

    // GPIO.
    cyc(1, 0, A_GPIO, 32'hA5A5_5A5A, 0);
    check("gpio_wr", gpio, 32'hA5A5_5A5A);

    // Fill past depth with the sink stalled.
    for (int i = 1; i <= 9; i++) cyc(1, 0, A_TXDATA, 32'(i), 0);
    check("fill_head", 32'(tx_data), 32'h01);
    cyc(0, 1, A_STATUS, 0, 0);
    check("status_ovf", r_data, 32'h0001_0208);
    cyc(1, 0, A_STATUS, 32'h0001_0000, 0);
    cyc(0, 1, A_STATUS, 0, 0);
    check("status_clr", r_data, 32'h0000_0208);

    // Drain under toggling backpressure.
    got.delete();
    for (int i = 0; i < 40 && got.size() < 8; i++) begin
      logic rdy;
      rdy = (i % 4 != 1);
      if (tx_valid && rdy) got.push_back(tx_data);
      cyc(0, 0, 0, 0, rdy);
    end
    check("drain_cnt", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++) check("drain_byte", 32'(got[k]), 32'(k + 1));
    check("drain_valid_low", 32'(tx_valid), 32'h0);
    cyc(0, 1, A_STATUS, 0, 0);
    check("status_empty", r_data, 32'h0000_0100);

    // Push while full with a same-cycle pop.
    for (int i = 0; i < 8; i++) cyc(1, 0, A_TXDATA, 32'h10 + 32'(i), 0);
    cyc(1, 0, A_TXDATA, 32'h55, 1);
    cyc(0, 1, A_STATUS, 0, 0);
    check("status_pushpop", r_data, 32'h0000_0208);
    got.delete();
    for (int i = 0; i < 40 && got.size() < 8; i++) begin
      if (tx_valid) got.push_back(tx_data);
      cyc(0, 0, 0, 0, 1);
    end
    check("pp_cnt", 32'(got.size()), 32'd8);
    if (got.size() == 8) begin
      check("pp_first", 32'(got[0]), 32'h11);
      check("pp_last", 32'(got[7]), 32'h55);
    end

    // Reset mid-drain.
    for (int i = 0; i < 3; i++) cyc(1, 0, A_TXDATA, 32'hC0 + 32'(i), 0);
    we = 0; tx_ready = 1;
    #1 rst = 1'b0;
    #1;
    check("rst_valid", 32'(tx_valid), 32'h0);
    check("rst_gpio", gpio, 32'h0);
    check("rst_rdata", r_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 1, A_STATUS, 0, 0);
    check("rst_status", r_data, 32'h0000_0100);
    cyc(0, 1, 32'h40, 0, 0);
    check("rst_ram", r_data, 32'hDEAD_BEEF);

    // Randomized traffic, checked by the compare process.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) < 5)
        a = 32'(($urandom_range(0, 3) << (RAM_AW + 2)) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      else
        a = 32'hFFFF_FF00 | 32'(offs[$urandom_range(0, 4)]);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 2) != 0));
    end
    cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
